// File: rtl/iterative_rotator_pkg.sv
// Shared definitions for the iterative shift/rotate unit: mode codes, FSM states,
// and the processor-side issue packet.
package iterative_rotator_pkg;

  localparam int unsigned REGISTER_SIZE = 32;
  localparam int unsigned MODE_W        = 3;
  localparam int unsigned REG_AMOUNT_W  = $clog2(REGISTER_SIZE);

  typedef enum logic [MODE_W-1:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    ASR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } rot_state_e;

  // Issue payload as the processor decode hands it to the unit.
  typedef struct packed {
    logic [REG_AMOUNT_W-1:0]  shift_amount;
    logic [REGISTER_SIZE-1:0] op;
    shift_mode_e              mode;
  } rotator_packet_t;

  function automatic logic is_legal_mode(input logic [MODE_W-1:0] code);
    return code <= MODE_W'(ROR);
  endfunction

endpackage

// File: rtl/iterative_rotator_if.sv
// Issue/result handshake bundle between the processor and the rotator unit.
interface iterative_rotator_if #(
  parameter int unsigned WIDTH = 32
);
  import iterative_rotator_pkg::*;

  localparam int unsigned AW = $clog2(WIDTH);

  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] in_mode;
  logic [WIDTH-1:0]  in_data;
  logic [AW-1:0]     in_amount;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_error;

  modport master (
    output in_valid, in_mode, in_data, in_amount, out_ready,
    input  in_ready, out_valid, out_data, out_error
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_amount, out_ready,
    output in_ready, out_valid, out_data, out_error
  );

endinterface

// File: rtl/iterative_rotator_stage.sv
// One logarithmic shifter stage: moves the value by 2**INDEX when enabled.
module iterative_rotator_stage
  import iterative_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 0
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  input  shift_mode_e      mode,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned DIST = 2 ** INDEX;

  // Illegal mode codes fall through unchanged so the operand passes straight out.
  always_comb begin
    result = value;
    if (enable) begin
      case (mode)
        SHL:     result = {value[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHR:     result = {{DIST{1'b0}}, value[WIDTH-1:DIST]};
        ASR:     result = {{DIST{sign}}, value[WIDTH-1:DIST]};
        ROL:     result = {value[WIDTH-DIST-1:0], value[WIDTH-1:WIDTH-DIST]};
        ROR:     result = {value[DIST-1:0], value[WIDTH-1:DIST]};
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/iterative_rotator.sv
// Multi-cycle shift/rotate unit: resolves STAGES_PER_CYCLE log-shifter stages per
// busy cycle behind a valid/ready issue port; constant latency of N busy cycles.
module iterative_rotator
  import iterative_rotator_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned STAGES_PER_CYCLE = 1
) (
  input logic           clock,
  input logic           reset_n,
  iterative_rotator_if.slave bus
);

  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned N  = (AW + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  rot_state_e       state_q, state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_error_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [AW-1:0]    amount_q;
  shift_mode_e      mode_q;
  logic             sign_q;

  logic load_c;
  logic step_c;
  logic last_step_c;

  logic [N-1:0][WIDTH-1:0] cycle_out;

  // One fixed-index stage chain per busy cycle; the counter selects which one applies.
  for (genvar c = 0; c < N; c++) begin : g_cycle
    logic [STAGES_PER_CYCLE:0][WIDTH-1:0] link;
    assign link[0] = work_q;
    for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_stage
      localparam int unsigned K = c * STAGES_PER_CYCLE + j;
      if (K < AW) begin : g_live
        iterative_rotator_stage #(
          .WIDTH (WIDTH),
          .INDEX (K)
        ) u_stage (
          .value  (link[j]),
          .enable (amount_q[K]),
          .mode   (mode_q),
          .sign   (sign_q),
          .result (link[j+1])
        );
      end else begin : g_pass
        assign link[j+1] = link[j];
      end
    end
    assign cycle_out[c] = link[STAGES_PER_CYCLE];
  end

  assign last_step_c = (cnt_q == CW'(N - 1));

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          load_c  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step_c = 1'b1;
        if (last_step_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so neither depends on
  // the same-cycle in_valid/out_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_error_q <= 1'b0;
      cnt_q       <= '0;
      work_q      <= '0;
      amount_q    <= '0;
      mode_q      <= SHL;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      if (load_c) begin
        work_q   <= bus.in_data;
        amount_q <= bus.in_amount;
        mode_q   <= shift_mode_e'(bus.in_mode);
        sign_q   <= bus.in_data[WIDTH-1];
        cnt_q    <= '0;
      end
      if (step_c) begin
        work_q <= cycle_out[cnt_q];
        cnt_q  <= last_step_c ? '0 : cnt_q + CW'(1);
      end
      // Result registers only move on entry to DONE.
      if (step_c && last_step_c) begin
        out_data_q  <= cycle_out[cnt_q];
        out_error_q <= !is_legal_mode(mode_q);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_error = out_error_q;

endmodule
